// File: rtl/csr_unit_pkg.sv
// Shared types, CSR address map and value helpers for the CSR access sequencer.
package csr_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  cntr_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    LSEL_MTVEC    = 2'd0,
    LSEL_MSCRATCH = 2'd1,
    LSEL_MEPC     = 2'd2,
    LSEL_MCAUSE   = 2'd3
  } lsel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int NUM_LOCAL = 4;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam cntr_t CNTR_CYCLE   = 2'b00;
  localparam cntr_t CNTR_INSTRET = 2'b10;

  // Bits that may hold a 1 in each local CSR; the rest read as zero.
  function automatic word_t csr_hw_mask(lsel_t sel);
    case (sel)
      LSEL_MTVEC: csr_hw_mask = 32'hFFFF_FFFC;
      LSEL_MEPC:  csr_hw_mask = 32'hFFFF_FFFE;
      default:    csr_hw_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic word_t csr_apply(csr_op_t op, word_t old_val, word_t operand);
    case (op)
      CSR_OP_RW: csr_apply = operand;
      CSR_OP_RS: csr_apply = old_val | operand;
      CSR_OP_RC: csr_apply = old_val & ~operand;
      default:   csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Request/response and counter-read signals between execute stage, counter bank and csr_unit.
interface csr_unit_if;
  import csr_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  word_t       req_wdata;
  logic        req_src_zero;
  logic        resp_valid;
  word_t       resp_rdata;
  logic        resp_illegal;
  cntr_t       cntr_addr;
  word_t       cntr_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_src_zero, cntr_data,
    output req_ready, resp_valid, resp_rdata, resp_illegal, cntr_addr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_src_zero, cntr_data,
    input  req_ready, resp_valid, resp_rdata, resp_illegal, cntr_addr
  );

endinterface

// File: rtl/csr_unit_decode.sv
// Combinational CSR address decode: mapping, counter routing, local select and read-only flag.
module csr_decode
  import csr_unit_pkg::*;
(
  input  logic [11:0] i_addr,
  input  csr_op_t     i_op,
  output logic        o_hit,
  output logic        o_is_counter,
  output cntr_t       o_cntr_addr,
  output lsel_t       o_local_sel,
  output logic        o_read_only
);

  logic w_mapped;

  always_comb begin
    w_mapped     = 1'b1;
    o_is_counter = 1'b0;
    o_cntr_addr  = CNTR_CYCLE;
    o_local_sel  = LSEL_MTVEC;
    case (i_addr)
      CSR_CYCLE, CSR_MCYCLE: begin
        o_is_counter = 1'b1;
        o_cntr_addr  = CNTR_CYCLE;
      end
      CSR_INSTRET, CSR_MINSTRET: begin
        o_is_counter = 1'b1;
        o_cntr_addr  = CNTR_INSTRET;
      end
      CSR_MTVEC:    o_local_sel = LSEL_MTVEC;
      CSR_MSCRATCH: o_local_sel = LSEL_MSCRATCH;
      CSR_MEPC:     o_local_sel = LSEL_MEPC;
      CSR_MCAUSE:   o_local_sel = LSEL_MCAUSE;
      default:      w_mapped = 1'b0;
    endcase
  end

  // A hit needs both a mapped address and a defined operation.
  assign o_hit       = w_mapped && (i_op != CSR_OP_NONE);
  assign o_read_only = o_is_counter || (i_addr[11:10] == 2'b11);

endmodule

// File: rtl/csr_unit.sv
// CSR access sequencer: IDLE accepts, READ captures the old value, WRITE updates and responds.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter word_t MTVEC_RESET = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  csr_unit_if.slave  bus
);

  state_t  r_state;
  state_t  w_state_next;
  csr_op_t r_op;
  word_t   r_wdata;
  logic    r_src_zero;
  logic    r_hit;
  logic    r_is_counter;
  logic    r_read_only;
  lsel_t   r_sel;
  cntr_t   r_cntr_addr;
  word_t   r_old;
  logic    r_illegal;
  word_t   r_csr [NUM_LOCAL];

  csr_op_t w_op;
  logic    w_hit;
  logic    w_is_counter;
  cntr_t   w_cntr_addr;
  lsel_t   w_local_sel;
  logic    w_read_only;
  logic    w_write_intent;
  logic    w_illegal;
  logic    w_csr_we;
  word_t   w_new;

  assign w_op = csr_op_t'(bus.req_op);

  csr_decode u_decode (
    .i_addr       (bus.req_addr),
    .i_op         (w_op),
    .o_hit        (w_hit),
    .o_is_counter (w_is_counter),
    .o_cntr_addr  (w_cntr_addr),
    .o_local_sel  (w_local_sel),
    .o_read_only  (w_read_only)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req_valid) w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Response is gated by rst so an aborted access never strobes.
  always_comb begin
    bus.req_ready    = (r_state == ST_IDLE) && !rst;
    bus.resp_valid   = (r_state == ST_WRITE) && !rst;
    bus.resp_illegal = bus.resp_valid && r_illegal;
    bus.resp_rdata   = (bus.resp_valid && !r_illegal) ? r_old : '0;
  end

  assign bus.cntr_addr = r_cntr_addr;

  assign w_write_intent = (r_op == CSR_OP_RW) || !r_src_zero;
  assign w_illegal      = !r_hit || (w_write_intent && r_read_only);
  assign w_new          = csr_apply(r_op, r_old, r_wdata);
  assign w_csr_we       = (r_state == ST_WRITE) && !r_illegal && w_write_intent;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= CSR_OP_NONE;
      r_wdata      <= '0;
      r_src_zero   <= 1'b0;
      r_hit        <= 1'b0;
      r_is_counter <= 1'b0;
      r_read_only  <= 1'b0;
      r_sel        <= LSEL_MTVEC;
      r_cntr_addr  <= '0;
      r_old        <= '0;
      r_illegal    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op         <= w_op;
            r_wdata      <= bus.req_wdata;
            r_src_zero   <= bus.req_src_zero;
            r_hit        <= w_hit;
            r_is_counter <= w_is_counter;
            r_read_only  <= w_read_only;
            r_sel        <= w_local_sel;
            r_cntr_addr  <= w_cntr_addr;
          end
        end
        ST_READ: begin
          r_old     <= r_is_counter ? bus.cntr_data : r_csr[r_sel];
          r_illegal <= w_illegal;
        end
        default: ;
      endcase
    end
  end

  // Local CSR file; stored values are always kept with hardwired bits cleared.
  for (genvar gi = 0; gi < NUM_LOCAL; gi++) begin : g_csr
    localparam word_t MASK      = csr_hw_mask(lsel_t'(gi));
    localparam word_t RESET_VAL = (gi == int'(LSEL_MTVEC)) ? (MTVEC_RESET & MASK) : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_csr[gi] <= RESET_VAL;
      end else if (w_csr_we && (r_sel == lsel_t'(gi))) begin
        r_csr[gi] <= w_new & MASK;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with a CSR-map model and a per-cycle response/handshake checker.
module tb_csr_unit;
  import csr_unit_pkg::*;

  localparam logic [31:0] MTVEC_INIT = 32'h8000_0103;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_unit_if bus ();

  csr_unit #(.MTVEC_RESET(MTVEC_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] cyc_val;
  logic [31:0] instret_val;
  assign bus.cntr_data = (bus.cntr_addr == 2'b10) ? instret_val :
                         (bus.cntr_addr == 2'b00) ? cyc_val : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = -100;
  logic rst_at_edge = 1'b1;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_csr [4];

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic model_reset();
    m_csr[0] = MTVEC_INIT & 32'hFFFF_FFFC;
    m_csr[1] = '0;
    m_csr[2] = '0;
    m_csr[3] = '0;
  endtask

  // CSR map as written in the architecture: address -> storage, legality, then update.
  task automatic model_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                           input logic sz, output logic [31:0] rd, output logic ill);
    bit mapped;
    bit cnt;
    bit wi;
    int idx;
    logic [31:0] old;
    logic [31:0] mask;
    logic [31:0] nv;
    mapped = 1; cnt = 0; idx = -1; old = '0; mask = 32'hFFFF_FFFF;
    case (a)
      12'hC00, 12'hB00: begin cnt = 1; old = cyc_val; end
      12'hC02, 12'hB02: begin cnt = 1; old = instret_val; end
      12'h305: begin idx = 0; mask = 32'hFFFF_FFFC; end
      12'h340: idx = 1;
      12'h341: begin idx = 2; mask = 32'hFFFF_FFFE; end
      12'h342: idx = 3;
      default: mapped = 0;
    endcase
    if (idx >= 0) old = m_csr[idx];
    wi  = (op == 2'b01) || !sz;
    ill = !mapped || (op == 2'b00) || (wi && (cnt || a[11:10] == 2'b11));
    rd  = ill ? 32'h0 : old;
    if (!ill && wi && idx >= 0) begin
      case (op)
        2'b01:   nv = wd;
        2'b10:   nv = old | wd;
        default: nv = old & ~wd;
      endcase
      m_csr[idx] = nv & mask;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_at_edge) begin
        check("reset_cntr_addr", {30'b0, bus.cntr_addr}, 32'h0);
        check("reset_resp_rdata", bus.resp_rdata, 32'h0);
        check("reset_resp_illegal", {31'b0, bus.resp_illegal}, 32'h0);
      end
      check("req_ready", {31'b0, bus.req_ready},
            {31'b0, (!rst && !(cyc >= acc_cyc && cyc <= acc_cyc + 1))});
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("resp_valid", {31'b0, bus.resp_valid}, 32'h1);
        check("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
        check("resp_illegal", {31'b0, bus.resp_illegal}, {31'b0, exp_q[0].ill});
        void'(exp_q.pop_front());
      end else begin
        check("resp_valid_quiet", {31'b0, bus.resp_valid}, 32'h0);
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic sz, input bit use_lit, input logic [31:0] lit_rd,
                        input logic lit_ill, input bit keep_valid, input bit abort);
    int waited;
    logic [31:0] prd;
    logic pill;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: got req_ready=0 for 20 cycles, required 1");
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_src_zero = sz;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!abort) begin
      model_req(op, addr, wd, sz, prd, pill);
      exp_q.push_back('{cyc + 1, prd, pill});
    end
    // Scramble the request lines; the accepted request must not see these.
    bus.req_valid    = keep_valid;
    bus.req_op       = 2'b01;
    bus.req_addr     = 12'h340;
    bus.req_wdata    = $urandom;
    bus.req_src_zero = 1'b0;
    @(posedge clk);
    #1;
    cyc_val     = cyc_val + 32'h1000;
    instret_val = instret_val + 32'h1000;
    if (abort) begin
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      @(negedge clk);
      if (use_lit) begin
        check("lit_rdata", bus.resp_rdata, lit_rd);
        check("lit_illegal", {31'b0, bus.resp_illegal}, {31'b0, lit_ill});
      end
    end
    $display("req op=%b addr=%h wdata=%h src_zero=%b abort=%0d -> rdata=%h illegal=%b",
             op, addr, wd, sz, abort, bus.resp_rdata, bus.resp_illegal);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_src_zero = 1'b0;
    cyc_val          = 32'h0000_0123;
    instret_val      = 32'h0000_0456;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    //     op     addr     wdata         sz  lit rdata         ill keep abort
    do_req(2'b10, 12'hC00, 32'h0,        1, 1, 32'h0000_0123, 0, 0, 0);
    do_req(2'b01, 12'h340, 32'hDEAD_BEEF, 0, 1, 32'h0,        0, 0, 0);
    do_req(2'b10, 12'h340, 32'h10,       0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    do_req(2'b10, 12'h340, 32'h0,        1, 1, 32'hDEAD_BEFF, 0, 0, 0);
    do_req(2'b01, 12'h341, 32'hFFFF_FFFF, 0, 1, 32'h0,        0, 0, 0);
    do_req(2'b11, 12'h341, 32'hF0,       0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    do_req(2'b10, 12'h341, 32'h0,        1, 1, 32'hFFFF_FF0E, 0, 0, 0);
    do_req(2'b01, 12'hC02, 32'h5,        0, 1, 32'h0,         1, 0, 0);
    do_req(2'b10, 12'hC02, 32'h0,        1, 1, 32'h0000_8456, 0, 0, 0);
    do_req(2'b10, 12'hB00, 32'h0,        1, 1, 32'h0000_9123, 0, 0, 0);
    do_req(2'b11, 12'hB02, 32'h1,        0, 1, 32'h0,         1, 0, 0);
    do_req(2'b10, 12'h305, 32'h0,        1, 1, 32'h8000_0100, 0, 0, 0);
    do_req(2'b01, 12'h305, 32'hFFFF_FFFF, 0, 1, 32'h8000_0100, 0, 0, 0);
    do_req(2'b10, 12'h305, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    do_req(2'b10, 12'h7C0, 32'h1,        0, 1, 32'h0,         1, 1, 0);
    do_req(2'b10, 12'h340, 32'h0,        1, 1, 32'hDEAD_BEFF, 0, 0, 0);
    do_req(2'b00, 12'h340, 32'h0,        0, 1, 32'h0,         1, 0, 0);
    do_req(2'b11, 12'h340, 32'hFFFF_FFFF, 1, 1, 32'hDEAD_BEFF, 0, 0, 0);
    do_req(2'b10, 12'h340, 32'h0,        1, 1, 32'hDEAD_BEFF, 0, 0, 0);
    do_req(2'b01, 12'h342, 32'h8000_000B, 0, 1, 32'h0,        0, 0, 0);
    do_req(2'b10, 12'h342, 32'h0,        1, 1, 32'h8000_000B, 0, 0, 0);
    do_req(2'b01, 12'hF11, 32'h7,        0, 1, 32'h0,         1, 0, 0);
    do_req(2'b10, 12'hF11, 32'h0,        1, 1, 32'h0,         1, 0, 0);
    do_req(2'b01, 12'h340, 32'h55,       0, 0, 32'h0,         0, 0, 1);
    do_req(2'b10, 12'h340, 32'h0,        1, 1, 32'h0,         0, 0, 0);
    do_req(2'b10, 12'h342, 32'h0,        1, 1, 32'h0,         0, 0, 0);
    do_req(2'b10, 12'h305, 32'h0,        1, 1, 32'h8000_0100, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
